multicycle_control: RTL and testbench

Multi-cycle sequencer for the RV32 core: replaces single-cycle opcode decoding with a state machine that drives the shared ALU, instruction register, PC and a single shared instruction/data memory port across several cycles per instruction. It sits between the instruction register (opcode source) and the datapath muxes/strobes. It handles a ready-based memory handshake with timeout, and traps on illegal opcodes or memory timeout.

---
 rtl/multicycle_control_if.sv | 30 +++
 rtl/multicycle_control.sv | 79 +++++++
 tb/tb_multicycle_control.sv | 135 +++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: sequencer <-> datapath/memory bundle (opcode, branch flag, memory handshake, mux selects, strobes, trap status)
interface multicycle_control_if;
  logic [6:0] opcode;
  logic       take_branch;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic       pc_src;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic       trap;
  logic [1:0] trap_cause;
  logic [3:0] state;
  modport master (
    input  opcode, take_branch, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, trap, trap_cause, state
  );
  modport slave (
    output opcode, take_branch, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, trap, trap_cause, state
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: RV32 multi-cycle sequencer; ports clk, rst (sync, active-high), bus (master: opcode/take_branch/mem_ready in, strobes/selects/trap/state out)
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  multicycle_control_if.master bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_READ = 4'd3, MEM_WB = 4'd4,
    MEM_WRITE = 4'd5, EXEC_R = 4'd6, EXEC_I = 4'd7, ALU_WB = 4'd8, BRANCH = 4'd9,
    JAL = 4'd10, LUI_WB = 4'd11, TRAP = 4'd12
  } state_t;
  state_t st;
  logic [7:0] cnt;
  logic [1:0] cause;
  logic req_st, tmo;
  assign req_st = st == FETCH || st == MEM_READ || st == MEM_WRITE;
  // counter holds the number of wait cycles already spent; the last allowed cycle is MEM_TIMEOUT-1
  assign tmo = req_st && !bus.mem_ready && cnt == 8'(MEM_TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= FETCH;
      cnt <= 8'd0;
      cause <= 2'b00;
    end else begin
      // any completed request leaves via mem_ready, so the next request state always starts from zero
      cnt <= (req_st && !bus.mem_ready) ? cnt + 8'd1 : 8'd0;
      if (tmo) begin
        st <= TRAP;
        cause <= 2'b10;
      end else begin
        case (st)
          FETCH:     st <= bus.mem_ready ? DECODE : FETCH;
          DECODE: begin
            case (bus.opcode)
              7'b0110011: st <= EXEC_R;
              7'b0010011: st <= EXEC_I;
              7'b0000011, 7'b0100011: st <= MEM_ADDR;
              7'b1100011: st <= BRANCH;
              7'b1101111: st <= JAL;
              7'b0110111: st <= LUI_WB;
              default: begin
                st <= TRAP;
                cause <= 2'b01;
              end
            endcase
          end
          MEM_ADDR:  st <= bus.opcode == 7'b0000011 ? MEM_READ : MEM_WRITE;
          MEM_READ:  st <= bus.mem_ready ? MEM_WB : MEM_READ;
          MEM_WRITE: st <= bus.mem_ready ? FETCH : MEM_WRITE;
          EXEC_R, EXEC_I: st <= ALU_WB;
          MEM_WB, ALU_WB, BRANCH, JAL, LUI_WB: st <= FETCH;
          default:   st <= TRAP;
        endcase
      end
    end
  end
  // outputs decode the registered state; everything is held at zero while rst is high
  assign bus.mem_req    = !rst && req_st;
  assign bus.mem_we     = !rst && st == MEM_WRITE;
  assign bus.iord       = !rst && (st == MEM_READ || st == MEM_WRITE);
  assign bus.ir_write   = !rst && st == FETCH && bus.mem_ready;
  assign bus.pc_write   = !rst && ((st == FETCH && bus.mem_ready) || (st == BRANCH && bus.take_branch) || st == JAL);
  assign bus.pc_src     = !rst && (st == BRANCH || st == JAL);
  assign bus.reg_write  = !rst && (st == MEM_WB || st == ALU_WB || st == JAL || st == LUI_WB);
  assign bus.alu_src_a  = rst ? 2'b00 :
                          st == DECODE ? 2'b01 :
                          (st == MEM_ADDR || st == EXEC_R || st == EXEC_I || st == BRANCH) ? 2'b10 : 2'b00;
  assign bus.alu_src_b  = rst ? 2'b00 :
                          st == FETCH ? 2'b10 :
                          (st == DECODE || st == MEM_ADDR || st == EXEC_I) ? 2'b01 : 2'b00;
  assign bus.alu_op     = rst ? 2'b00 : st == EXEC_R ? 2'b10 : st == BRANCH ? 2'b01 : 2'b00;
  assign bus.result_src = rst ? 2'b00 :
                          st == MEM_WB ? 2'b01 : st == JAL ? 2'b10 : st == LUI_WB ? 2'b11 : 2'b00;
  assign bus.trap       = !rst && st == TRAP;
  assign bus.trap_cause = rst ? 2'b00 : cause;
  assign bus.state      = rst ? 4'd0 : st;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed-vector check of the multi-cycle sequencer
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  multicycle_control_if bus ();
  multicycle_control #(.MEM_TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [21:0] outv;
  assign outv = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write, bus.pc_src,
                 bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src,
                 bus.trap, bus.trap_cause, bus.state};
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_LUI = 7'b0110111, OP_BAD = 7'b1111111;
  function automatic logic [21:0] mk(input int rq, we, io, irw, pcw, pcs, rw, a, b, op, rs, tr, tc, st);
    logic [21:0] v;
    v = {rq[0], we[0], io[0], irw[0], pcw[0], pcs[0], rw[0], a[1:0], b[1:0], op[1:0], rs[1:0], tr[0], tc[1:0], st[3:0]};
    return v;
  endfunction
  task automatic chk(input string tag, input logic [21:0] got, input logic [21:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic [21:0] exp);
    #1 chk(tag, outv, exp);
    @(posedge clk);
    #1;
  endtask
  logic [21:0] v_fetch_acc, v_fetch_wait, v_decode, v_zero;
  initial begin
    #200000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1);
  end
  initial begin
    v_fetch_acc  = mk(1,0,0,1,1,0,0, 0,2,0,0, 0,0,0);
    v_fetch_wait = mk(1,0,0,0,0,0,0, 0,2,0,0, 0,0,0);
    v_decode     = mk(0,0,0,0,0,0,0, 1,1,0,0, 0,0,1);
    v_zero       = 22'd0;
    bus.opcode = OP_R;
    bus.take_branch = 1'b0;
    bus.mem_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("rst_hold", v_zero);
    rst = 1'b0;
    step("add_fetch", v_fetch_acc);
    step("add_decode", v_decode);
    step("add_exec", mk(0,0,0,0,0,0,0, 2,0,2,0, 0,0,6));
    step("add_wb", mk(0,0,0,0,0,0,1, 0,0,0,0, 0,0,8));
    bus.opcode = OP_LD;
    step("ld_fetch", v_fetch_acc);
    step("ld_decode", v_decode);
    step("ld_addr", mk(0,0,0,0,0,0,0, 2,1,0,0, 0,0,2));
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("ld_wait", mk(1,0,1,0,0,0,0, 0,0,0,0, 0,0,3));
    bus.mem_ready = 1'b1;
    step("ld_read", mk(1,0,1,0,0,0,0, 0,0,0,0, 0,0,3));
    step("ld_wb", mk(0,0,0,0,0,0,1, 0,0,0,1, 0,0,4));
    bus.opcode = OP_ST;
    step("st_fetch", v_fetch_acc);
    step("st_decode", v_decode);
    step("st_addr", mk(0,0,0,0,0,0,0, 2,1,0,0, 0,0,2));
    step("st_write", mk(1,1,1,0,0,0,0, 0,0,0,0, 0,0,5));
    bus.opcode = OP_BR;
    bus.take_branch = 1'b1;
    step("beq_t_fetch", v_fetch_acc);
    step("beq_t_decode", v_decode);
    step("beq_taken", mk(0,0,0,0,1,1,0, 2,0,1,0, 0,0,9));
    bus.take_branch = 1'b0;
    step("beq_n_fetch", v_fetch_acc);
    step("beq_n_decode", v_decode);
    step("beq_not", mk(0,0,0,0,0,1,0, 2,0,1,0, 0,0,9));
    bus.opcode = OP_JAL;
    step("jal_fetch", v_fetch_acc);
    step("jal_decode", v_decode);
    step("jal", mk(0,0,0,0,1,1,1, 0,0,0,2, 0,0,10));
    bus.opcode = OP_LUI;
    step("lui_fetch", v_fetch_acc);
    step("lui_decode", v_decode);
    step("lui_wb", mk(0,0,0,0,0,0,1, 0,0,0,3, 0,0,11));
    bus.opcode = OP_I;
    step("addi_fetch", v_fetch_acc);
    step("addi_decode", v_decode);
    step("addi_exec", mk(0,0,0,0,0,0,0, 2,1,0,0, 0,0,7));
    step("addi_wb", mk(0,0,0,0,0,0,1, 0,0,0,0, 0,0,8));
    bus.opcode = OP_R;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step("late_wait", v_fetch_wait);
    bus.mem_ready = 1'b1;
    step("late_accept", v_fetch_acc);
    step("late_decode", v_decode);
    step("late_exec", mk(0,0,0,0,0,0,0, 2,0,2,0, 0,0,6));
    step("late_wb", mk(0,0,0,0,0,0,1, 0,0,0,0, 0,0,8));
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) step("tmo_wait", v_fetch_wait);
    step("tmo_trap", mk(0,0,0,0,0,0,0, 0,0,0,0, 1,2,12));
    rst = 1'b1;
    step("tmo_rst", v_zero);
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode = OP_BAD;
    step("ill_fetch", v_fetch_acc);
    step("ill_decode", v_decode);
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = i[0];
      bus.take_branch = i[1];
      step("ill_trap", mk(0,0,0,0,0,0,0, 0,0,0,0, 1,1,12));
    end
    rst = 1'b1;
    step("ill_rst", v_zero);
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode = OP_LD;
    step("post_trap_fetch", v_fetch_acc);
    step("mid_decode", v_decode);
    step("mid_addr", mk(0,0,0,0,0,0,0, 2,1,0,0, 0,0,2));
    bus.mem_ready = 1'b0;
    step("mid_wait", mk(1,0,1,0,0,0,0, 0,0,0,0, 0,0,3));
    bus.mem_ready = 1'b1;
    rst = 1'b1;
    step("mid_rst", v_zero);
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    step("mid_refetch", v_fetch_wait);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
